// File: rtl/sram_pixel_writer.sv
`default_nettype none
// ============================================================================
// sram_pixel_writer: packs a stream of 8-bit pixels into masked 32-bit SRAM
// word writes at consecutive (ADDR_STEP-spaced) word addresses.
// Revision: 1.0
// ============================================================================
module sram_pixel_writer #(
  parameter logic [17:0] ADDR_STEP = 18'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [19:0] pixel_count,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [53:0] wr_din,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [19:0] remaining_q, remaining_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        pix_fire, wr_fire, word_full;

  assign pix_fire  = (state_q == S_FILL) && pix_valid;
  assign wr_fire   = (state_q == S_SEND) && wr_ready;
  // The accepted pixel closes the word if it fills lane 3 or is the frame's last.
  assign word_full = (lane_q == 2'd3) || (remaining_q == 20'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (pixel_count != 20'd0) ? S_FILL : S_FINISH;
      S_FILL:   if (pix_fire && word_full) state_d = S_SEND;
      S_SEND:   if (wr_fire) state_d = (remaining_q != 20'd0) ? S_FILL : S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == S_FILL);
    wr_valid  = (state_q == S_SEND);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FINISH);
  end

  assign wr_din = {mask_q, addr_q, data_q};

  always_comb begin
    lane_d      = lane_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = pixel_count;
          lane_d      = 2'd0;
          data_d      = 32'd0;
          mask_d      = 4'd0;
        end
      end
      S_FILL: begin
        if (pix_valid) begin
          data_d[{lane_q, 3'b000} +: 8] = pix_data;
          mask_d[lane_q]                = 1'b1;
          lane_d                        = lane_q + 2'd1;
          remaining_d                   = remaining_q - 20'd1;
        end
      end
      S_SEND: begin
        if (wr_ready) begin
          addr_d = addr_q + ADDR_STEP;
          lane_d = 2'd0;
          data_d = 32'd0;
          mask_d = 4'd0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q      <= 2'd0;
      remaining_q <= 20'd0;
      addr_q      <= 18'd0;
      data_q      <= 32'd0;
      mask_q      <= 4'd0;
    end else begin
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_pixel_writer.sv
`default_nettype none
// ============================================================================
// tb_sram_pixel_writer: directed and random frames against a word-level model;
// two instances (ADDR_STEP 1 and 4) share all stimulus.
// Revision: 1.0
// ============================================================================
module tb_sram_pixel_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [19:0] pixel_count = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        wr_ready = 1'b0;

  logic        pix_ready0, wr_valid0, busy0, done0;
  logic [53:0] wr_din0;
  logic        pix_ready1, wr_valid1, busy1, done1;
  logic [53:0] wr_din1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  pix_q[$];
  logic [53:0] exp0[$], exp1[$], got0[$], got1[$];

  sram_pixel_writer dut0 (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .pixel_count(pixel_count), .pix_valid(pix_valid), .pix_ready(pix_ready0),
    .pix_data(pix_data), .wr_valid(wr_valid0), .wr_ready(wr_ready),
    .wr_din(wr_din0), .busy(busy0), .done(done0)
  );

  sram_pixel_writer #(.ADDR_STEP(18'd4)) dut1 (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .pixel_count(pixel_count), .pix_valid(pix_valid), .pix_ready(pix_ready1),
    .pix_data(pix_data), .wr_valid(wr_valid1), .wr_ready(wr_ready),
    .wr_din(wr_din1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word w of an n-pixel frame: pixels 4w..4w+3, absent lanes zero/unmasked.
  function automatic logic [53:0] model_word(input logic [17:0] base, input int step,
                                             input int w, input int n);
    logic [3:0]  m = '0;
    logic [31:0] d = '0;
    logic [17:0] a;
    for (int k = 0; k < 4; k++) begin
      if (4 * w + k < n) begin
        m[k]         = 1'b1;
        d[8*k +: 8]  = pix_q[4*w+k];
      end
    end
    a = 18'((int'(base) + w * step) % 262144);
    return {m, a, d};
  endfunction

  task automatic fill_pixels(input int n, input logic [7:0] first, input bit rnd);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
  endtask

  // rmode: 0 always ready, 1 random ready, 2 hold ready low 10 cycles per word.
  // vmode: 0 valid whenever pixels remain, 1 random valid plus junk start pulses.
  task automatic run_frame(input logic [17:0] base, input int n, input int rmode, input int vmode);
    int          idx = 0;
    int          cyc = 0;
    int          stall_left = 0;
    int          nwords;
    bit          done_seen = 0;
    bit          hold = 0;
    bit          prev_v = 0;
    logic        r0, v0, v1;
    logic [53:0] prev0 = '0, prev1 = '0;
    logic [63:0] e;
    nwords = (n + 3) / 4;
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    for (int w = 0; w < nwords; w++) begin
      exp0.push_back(model_word(base, 1, w, n));
      exp1.push_back(model_word(base, 4, w, n));
    end
    @(negedge clock);
    start = 1'b1; base_addr = base; pixel_count = 20'(n); pix_valid = 1'b0; wr_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    while (!done_seen && cyc < 2000) begin
      r0 = pix_ready0; v0 = wr_valid0; v1 = wr_valid1;
      check_value("busy", busy0, 1);
      check_value("ready_valid_excl", r0 & v0, 0);
      if (idx == n) check_value("ready_after_last", r0, 0);
      if (hold) begin
        check_value("stall_din0", wr_din0, prev0);
        check_value("stall_din1", wr_din1, prev1);
        check_value("stall_valid", v0, 1);
        check_value("stall_ready", r0, 0);
      end
      if (done0) begin
        done_seen = 1;
        check_value("done_pixels", idx, n);
        check_value("done_left0", exp0.size(), 0);
        check_value("done_left1", exp1.size(), 0);
        check_value("nwords0", got0.size(), nwords);
        check_value("nwords1", got1.size(), nwords);
        if (rmode == 0 && vmode == 0) check_value("done_latency", cyc, n + nwords);
        start = 1'b0; pix_valid = 1'b0; wr_ready = 1'b0;
      end else begin
        case (rmode)
          0: wr_ready = 1'b1;
          1: wr_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (v0 && !prev_v) stall_left = 10;
            wr_ready = (stall_left == 0);
            if (v0 && stall_left > 0) stall_left--;
          end
        endcase
        pix_valid = (vmode == 0) ? (idx < n) : 1'($urandom_range(0, 1));
        pix_data  = (idx < n) ? pix_q[idx] : 8'($urandom);
        if (vmode == 1 && $urandom_range(0, 7) == 0) begin
          start = 1'b1; base_addr = 18'($urandom); pixel_count = 20'($urandom_range(0, 50));
        end else begin
          start = 1'b0;
        end
        if (v0 && wr_ready) begin
          if (exp0.size() > 0) e = 64'(exp0.pop_front()); else e = '1;
          check_value("word0", wr_din0, e);
          got0.push_back(wr_din0);
        end
        if (v1 && wr_ready) begin
          if (exp1.size() > 0) e = 64'(exp1.pop_front()); else e = '1;
          check_value("word1", wr_din1, e);
          got1.push_back(wr_din1);
        end
        if (r0 && pix_valid) idx++;
      end
      hold   = v0 && !wr_ready;
      prev_v = v0;
      prev0  = wr_din0;
      prev1  = wr_din1;
      @(negedge clock);
      cyc++;
    end
    if (!done_seen) check_value("done_timeout", cyc, 0);
    check_value("done_one_cycle", done0, 0);
    check_value("idle_busy", busy0, 0);
    check_value("idle_done1", done1, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_ctl0"}, {pix_ready0, wr_valid0, busy0, done0}, 0);
    check_value({tag, "_din0"}, wr_din0, 0);
    check_value({tag, "_ctl1"}, {pix_ready1, wr_valid1, busy1, done1}, 0);
    check_value({tag, "_din1"}, wr_din1, 0);
  endtask

  task automatic reset_mid_frame();
    @(negedge clock);
    start = 1'b1; base_addr = 18'h00200; pixel_count = 20'd4; pix_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h50 + 8'(i);
      @(negedge clock);
    end
    pix_valid = 1'b0;
    check_value("pre_reset_busy", busy0, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    pix_valid = 1'b1;
    @(negedge clock);
    check_all_zero("in_reset");
    reset = 1'b0;
    pix_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_value("post_reset_wr", wr_valid0, 0);
      check_value("post_reset_busy", busy0, 0);
    end
  endtask

  logic [53:0] w;

  initial begin
    repeat (2) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b0;

    fill_pixels(8, 8'h01, 0);
    run_frame(18'h00010, 8, 0, 0);
    check_value("t1_count", got0.size(), 2);
    if (got0.size() == 2) begin
      check_value("t1_w0", got0[0], {4'hF, 18'h00010, 32'h04030201});
      check_value("t1_w1", got0[1], {4'hF, 18'h00011, 32'h08070605});
    end

    fill_pixels(6, 8'hAA, 0);
    run_frame(18'h00010, 6, 0, 0);
    check_value("t2_count", got0.size(), 2);
    if (got0.size() == 2) check_value("t2_w1", got0[1], {4'h3, 18'h00011, 32'h0000AFAE});

    fill_pixels(0, 8'h00, 0);
    run_frame(18'h00055, 0, 0, 0);

    fill_pixels(8, 8'h00, 1);
    run_frame(18'h00020, 8, 2, 0);

    fill_pixels(8, 8'h00, 1);
    run_frame(18'h3FFFF, 8, 0, 0);
    if (got0.size() == 2 && got1.size() == 2) begin
      w = got0[0]; check_value("wrap_a0", w[49:32], 18'h3FFFF);
      w = got0[1]; check_value("wrap_a1", w[49:32], 18'h00000);
      w = got1[1]; check_value("wrap_step4_a1", w[49:32], 18'h00003);
    end else begin
      check_value("wrap_count", got0.size() + got1.size(), 4);
    end

    fill_pixels(8, 8'h00, 1);
    run_frame(18'h00100, 8, 0, 0);
    if (got1.size() == 2) begin
      w = got1[0]; check_value("step4_a0", w[49:32], 18'h00100);
      w = got1[1]; check_value("step4_a1", w[49:32], 18'h00104);
    end else begin
      check_value("step4_count", got1.size(), 2);
    end

    reset_mid_frame();
    fill_pixels(4, 8'hC0, 0);
    run_frame(18'h00040, 4, 0, 0);
    if (got0.size() == 1) check_value("after_reset_w0", got0[0], {4'hF, 18'h00040, 32'hC3C2C1C0});
    else check_value("after_reset_count", got0.size(), 1);

    repeat (30) begin
      int n;
      n = $urandom_range(0, 37);
      fill_pixels(n, 8'h00, 1);
      run_frame(18'($urandom), n, 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
